// File: rtl/sb_spram_256ka_if.sv
// Bus bundle for the 16K x 16 single-port RAM: access controls, power controls and read data.
interface sb_spram_256ka_if;
  logic        chipselect;
  logic [13:0] address;
  logic [15:0] datain;
  logic [3:0]  maskwren;
  logic        wren;
  logic        standby;
  logic        sleep;
  logic        poweroff;  // active-low: 0 = powered off
  logic [15:0] dataout;

  modport master (
    output chipselect, address, datain, maskwren, wren, standby, sleep, poweroff,
    input  dataout
  );

  modport slave (
    input  chipselect, address, datain, maskwren, wren, standby, sleep, poweroff,
    output dataout
  );
endinterface

// File: rtl/sb_spram_256ka.sv
// 16384 x 16 single-port RAM with nibble write masks, registered read data and
// standby/sleep/power-off controls.
module sb_spram_256ka (
  input  logic                    clk_i,
  input  logic                    rst_i,
  sb_spram_256ka_if.slave         bus_io
);

  logic [15:0] mem [16384];
  logic [15:0] dataout_q = 16'h0000;
  logic [15:0] dataout_d;

  logic pwr_blocked;
  logic idle;
  logic wr_en;
  logic rd_en;

  // Power-down beats idle, idle beats access; reset beats everything.
  assign pwr_blocked = !bus_io.poweroff || bus_io.sleep;
  assign idle        = bus_io.standby || !bus_io.chipselect;
  assign wr_en       = !rst_i && !pwr_blocked && !idle && bus_io.wren;
  assign rd_en       = !rst_i && !pwr_blocked && !idle && !bus_io.wren;

  always_comb begin
    dataout_d = dataout_q;
    if (rst_i || pwr_blocked) begin
      dataout_d = 16'h0000;
    end else if (rd_en) begin
      dataout_d = mem[bus_io.address];
    end
  end

  always_ff @(posedge clk_i) begin
    dataout_q <= dataout_d;
  end

  // Array is never reset; a nibble is only touched when its mask bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_io.maskwren[i]) begin
          mem[bus_io.address][4*i +: 4] <= bus_io.datain[4*i +: 4];
        end
      end
    end
  end

  assign bus_io.dataout = dataout_q;

endmodule

// File: tb/tb_sb_spram_256ka.sv
// Randomized bench for sb_spram_256ka: behavioural RAM model with per-nibble knowledge
// tracking, checked every cycle, plus directed literal checks of the key scenarios.
module tb_sb_spram_256ka;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sb_spram_256ka_if bus ();

  sb_spram_256ka dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: sparse word store plus which nibbles hold defined data.
  logic [15:0] m_word [int];
  logic [3:0]  m_known [int];
  logic [15:0] exp_dout = 16'h0000;
  logic [15:0] exp_kmask = 16'hFFFF;

  function automatic logic [15:0] nib_bits(input logic [3:0] k);
    return {{4{k[3]}}, {4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
  endfunction

  always @(posedge clk) begin
    int a;
    a = int'(bus.address);
    if (rst) begin
      exp_dout  = 16'h0000;
      exp_kmask = 16'hFFFF;
    end else if (!bus.poweroff || bus.sleep) begin
      exp_dout  = 16'h0000;
      exp_kmask = 16'hFFFF;
      if (!bus.poweroff) begin
        m_word.delete();
        m_known.delete();
      end
    end else if (bus.standby || !bus.chipselect) begin
      // nothing changes
    end else if (bus.wren) begin
      if (!m_word.exists(a)) begin
        m_word[a]  = 16'h0000;
        m_known[a] = 4'h0;
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.maskwren[i]) begin
          m_word[a][4*i +: 4] = bus.datain[4*i +: 4];
          m_known[a][i]       = 1'b1;
        end
      end
    end else begin
      if (m_word.exists(a)) begin
        exp_dout  = m_word[a];
        exp_kmask = nib_bits(m_known[a]);
      end else begin
        exp_dout  = 16'h0000;
        exp_kmask = 16'h0000;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    n_tests++;
    if ((bus.dataout & exp_kmask) !== (exp_dout & exp_kmask)) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t dataout=%h required=%h (mask %h)",
               $time, bus.dataout, exp_dout, exp_kmask);
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Pins both the DUT and the model to a hand-computed literal.
  task automatic check_lit(input string name, input logic [15:0] req);
    check({name, "_dut"}, bus.dataout, req);
    check({name, "_model"}, exp_dout, req);
  endtask

  task automatic cyc(input logic r, input logic cs, input logic [13:0] addr,
                     input logic [15:0] din, input logic [3:0] mask, input logic we,
                     input logic stby, input logic slp, input logic pwr);
    rst             = r;
    bus.chipselect  = cs;
    bus.address     = addr;
    bus.datain      = din;
    bus.maskwren    = mask;
    bus.wren        = we;
    bus.standby     = stby;
    bus.sleep       = slp;
    bus.poweroff    = pwr;
    @(negedge clk);
  endtask

  task automatic wr(input logic [13:0] addr, input logic [15:0] din, input logic [3:0] mask);
    cyc(1'b0, 1'b1, addr, din, mask, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [13:0] addr);
    cyc(1'b0, 1'b1, addr, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [13:0] addr;
    logic [15:0] din;
    logic [3:0]  mask;
    int          sel;

    rst = 1'b1;
    bus.chipselect = 1'b0;
    bus.address    = '0;
    bus.datain     = '0;
    bus.maskwren   = '0;
    bus.wren       = 1'b0;
    bus.standby    = 1'b0;
    bus.sleep      = 1'b0;
    bus.poweroff   = 1'b1;
    #1;
    check("initial_dout", bus.dataout, 16'h0000);
    @(negedge clk);
    check_lit("reset_dout", 16'h0000);
    cyc(1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full write then read.
    wr(14'h0010, 16'hA5C3, 4'hF);
    check_lit("write_holds_dout", 16'h0000);
    rd(14'h0010);
    check_lit("read_a5c3", 16'hA5C3);

    // Masked merge.
    wr(14'h0020, 16'hFFFF, 4'hF);
    wr(14'h0020, 16'h1234, 4'b0101);
    rd(14'h0020);
    check_lit("mask_merge", 16'hF2F4);

    // Zero mask leaves the word alone.
    wr(14'h0020, 16'h0000, 4'h0);
    rd(14'h0020);
    check_lit("mask_zero", 16'hF2F4);

    // Address extremes.
    wr(14'h3FFF, 16'h0BEE, 4'hF);
    wr(14'h0000, 16'h0CAF, 4'hF);
    rd(14'h3FFF);
    check_lit("addr_top", 16'h0BEE);
    rd(14'h0000);
    check_lit("addr_zero", 16'h0CAF);

    // Hold through write and deselect.
    rd(14'h0010);
    check_lit("hold_read", 16'hA5C3);
    wr(14'h0030, 16'h7777, 4'hF);
    check_lit("hold_write", 16'hA5C3);
    cyc(1'b0, 1'b0, 14'h0030, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_lit("hold_deselect", 16'hA5C3);
    cyc(1'b0, 1'b1, 14'h0030, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_lit("hold_standby", 16'hA5C3);

    // Sleep forces zero and blocks the write.
    cyc(1'b0, 1'b1, 14'h0010, 16'h0000, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
    check_lit("sleep_zero", 16'h0000);
    cyc(1'b0, 1'b1, 14'h0010, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_lit("sleep_stays_zero", 16'h0000);
    rd(14'h0010);
    check_lit("sleep_retained", 16'hA5C3);

    // Reset aborts a concurrent write.
    cyc(1'b1, 1'b1, 14'h0010, 16'h5555, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    check_lit("reset_zero", 16'h0000);
    rd(14'h0010);
    check_lit("reset_no_write", 16'hA5C3);

    // Write-then-read in consecutive cycles.
    wr(14'h0040, 16'h3C3C, 4'b1001);
    rd(14'h0040);
    check("wr_then_rd_known", bus.dataout & 16'hF00F, 16'h300C);

    // Randomized traffic over a small address window plus the extremes.
    for (int n = 0; n < 4000; n++) begin
      sel  = int'($urandom_range(0, 99));
      addr = ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
      din  = 16'($urandom);
      mask = 4'($urandom);
      if (sel < 1) begin
        cyc(1'b0, 1'b1, addr, din, mask, 1'($urandom), 1'b0, 1'b0, 1'b0);
      end else if (sel < 3) begin
        cyc(1'b1, 1'b1, addr, din, mask, 1'($urandom), 1'b0, 1'b0, 1'b1);
      end else if (sel < 7) begin
        cyc(1'b0, 1'b1, addr, din, mask, 1'($urandom), 1'($urandom), 1'b1, 1'b1);
      end else if (sel < 13) begin
        cyc(1'b0, 1'($urandom), addr, din, mask, 1'($urandom), 1'b1, 1'b0, 1'b1);
      end else if (sel < 18) begin
        cyc(1'b0, 1'b0, addr, din, mask, 1'($urandom), 1'b0, 1'b0, 1'b1);
      end else if (sel < 55) begin
        wr(addr, din, mask);
      end else begin
        rd(addr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_spram_256ka.md
SB_SPRAM_256KA -- requirements
Module: sb_spram_256ka

Interface
REQ-001 Parameters: none; geometry is fixed at 16384 words x 16 bits.
REQ-002 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 CHIPSELECT  input  1  access enable; low = no read, no write, DATAOUT holds.
REQ-005 ADDRESS  input  14  word address 0..16383; narrower callers zero-extend.
REQ-006 DATAIN  input  16  write data.
REQ-007 MASKWREN  input  4  per-nibble write enable; bit i covers DATAIN/array bits [4i+3:4i].
REQ-008 WREN  input  1  1 = write cycle, 0 = read cycle.
REQ-009 STANDBY  input  1  active-high; blocks access, retains contents, DATAOUT holds.
REQ-010 SLEEP  input  1  active-high; blocks access, retains contents, DATAOUT forced to 0.
REQ-011 POWEROFF  input  1  active-LOW; 0 = powered off, no access, DATAOUT forced to 0.
REQ-012 DATAOUT  output  16  registered read data.

Function
REQ-013 Storage: 16384 x 16-bit array; no reset or initialisation of array contents.
REQ-014 Access is enabled ("en") when CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1.
REQ-015 Write: on rising CLOCK with en and WREN=1, each nibble i with MASKWREN[i]=1 is replaced by DATAIN nibble i; nibbles with MASKWREN[i]=0 are unchanged.
REQ-016 WREN=1 with MASKWREN=4'b0000 leaves the array unchanged.
REQ-017 Read: on rising CLOCK with en and WREN=0, DATAOUT <= array[ADDRESS]; latency is exactly 1 cycle.
REQ-018 During a write cycle DATAOUT holds its previous value (no write-through).
REQ-019 A read of an address in the cycle after it was written returns the newly written (merged) word.
REQ-020 CHIPSELECT=0 or STANDBY=1: no array change, DATAOUT holds.
REQ-021 SLEEP=1 or POWEROFF=0: no array change; DATAOUT is 0 from the next rising edge onward and stays 0 while the condition persists.
REQ-022 Array contents after any cycle with POWEROFF=0 are unspecified; contents across STANDBY and SLEEP are retained.
REQ-023 Priority per edge: RESET > (POWEROFF=0 or SLEEP=1) > (STANDBY=1 or CHIPSELECT=0) > write/read.
REQ-024 ADDRESS wraps naturally within 14 bits; no out-of-range condition exists.
REQ-025 No combinational path from any input to DATAOUT.

Reset
REQ-026 RESET=1 at a rising edge sets DATAOUT to 16'h0000 and suppresses any read or write in that cycle.
REQ-027 RESET does not modify array contents; a mid-operation reset aborts only the access in that cycle.
REQ-028 Before the first reset or read, DATAOUT is 16'h0000 (initial value).

Verification
REQ-029 Write 16'hA5C3 to 14'h0010 (MASKWREN=4'hF), then read 14'h0010 -> DATAOUT=16'hA5C3 one cycle after the read edge.
REQ-030 Preload 16'hFFFF at 14'h0020, write 16'h1234 with MASKWREN=4'b0101, read back -> 16'hF2F4.
REQ-031 Write 16'h0BEE at 14'h3FFF and 16'h0CAF at 14'h0000, read both -> 16'h0BEE and 16'h0CAF (no aliasing at the extremes).
REQ-032 Read 16'hA5C3 so DATAOUT=16'hA5C3, then write 16'h7777 elsewhere, then a cycle with CHIPSELECT=0 -> DATAOUT stays 16'hA5C3 throughout.
REQ-033 With DATAOUT=16'hA5C3 assert SLEEP=1 -> DATAOUT=0 next edge; attempted write ignored; deassert SLEEP and read -> original contents returned.
REQ-034 Assert RESET together with a write of 16'h5555 to 14'h0010 (previously holding 16'hA5C3) -> DATAOUT=0, subsequent read returns 16'hA5C3.
